// File: rtl/int_mul_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
//   out_state_t : occupancy of the single result register (EMPTY / FULL)
//   id_width()  : width of a requester index; one bit minimum so that a
//                 single-requester build still has a legal out_id port
package int_mul_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/int_multiply.sv
// Combinational signed multiplier producing the full-width product.
//   a : signed operand, A_WIDTH bits
//   b : signed operand, B_WIDTH bits
//   p : signed product, A_WIDTH+B_WIDTH bits (exact, never overflows)
module int_multiply #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

  // Both operands are signed, so they are sign-extended to the product
  // width before multiplying.
  assign p = a * b;

endmodule

// File: rtl/int_multiply_arbiter.sv
// Shares one signed multiplier between NUM_REQ requesters.
// Round-robin arbitration picks one valid requester per cycle; its product
// is captured in a single output register tagged with the requester index.
//   clk, rst   : clock, synchronous active-high reset
//   req_a/b    : per-requester signed operands
//   req_valid  : per-requester operand pair valid
//   req_ready  : per-requester accept (at most one bit high)
//   out_data   : registered signed product
//   out_id     : index of the requester that produced out_data
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
module int_multiply_arbiter
  import int_mul_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int A_WIDTH  = 8,
  parameter  int B_WIDTH  = 8,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [NUM_REQ-1:0][A_WIDTH-1:0]  req_a,
  input  logic signed [NUM_REQ-1:0][B_WIDTH-1:0]  req_b,
  input  logic        [NUM_REQ-1:0]               req_valid,
  output logic        [NUM_REQ-1:0]               req_ready,
  output logic signed [A_WIDTH+B_WIDTH-1:0]       out_data,
  output logic        [ID_WIDTH-1:0]              out_id,
  output logic                                    out_valid,
  input  logic                                    out_ready
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  out_state_t                  state, state_next;
  logic [ID_WIDTH-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]          grant;
  logic [ID_WIDTH-1:0]         gnt_idx;
  logic                        gnt_any;
  logic [ID_WIDTH-1:0]         idx;
  logic signed [A_WIDTH-1:0]   a_sel;
  logic signed [B_WIDTH-1:0]   b_sel;
  logic signed [P_WIDTH-1:0]   prod_p0;
  logic                        can_accept;
  logic                        xfer_in;
  logic                        xfer_out;

  // ---- stage p0: arbitration, operand mux, multiply ----

  // Walk 2*NUM_REQ indices so the search starting at rr_ptr wraps around
  // without a modulo on the pointer. Only req_valid and rr_ptr steer the
  // grant; operands merely follow it through the mux, which keeps
  // req_ready free of any combinational path from req_a/req_b.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      idx = ID_WIDTH'(i % NUM_REQ);
      if (!gnt_any && (i >= int'(rr_ptr)) && req_valid[idx]) begin
        gnt_any      = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
        a_sel        = $signed(req_a[idx]);
        b_sel        = $signed(req_b[idx]);
      end
    end
  end

  int_multiply #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_mul (
    .a (a_sel),
    .b (b_sel),
    .p (prod_p0)
  );

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  // Reset gating keeps requesters from seeing an accept that the register
  // will not honour.
  assign req_ready  = (can_accept && !rst) ? grant : '0;
  assign xfer_in    = gnt_any && can_accept && !rst;
  assign xfer_out   = out_valid && out_ready;

  // Output occupancy: a new accept always wins (also when draining in the
  // same cycle), otherwise a drain empties the register.
  always_comb begin
    state_next = state;
    if (xfer_in) begin
      state_next = FULL;
    end else if (xfer_out) begin
      state_next = EMPTY;
    end
  end

  // ---- stage p1: output register ----

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The pointer only advances on an actual requester transfer, so a
  // stalled output never rotates priority away from the pending grant.
  // With NUM_REQ=1 both branches evaluate to zero, keeping it constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer_in) begin
      rr_ptr <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Data and tag hold their last values after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_id   <= '0;
    end else if (xfer_in) begin
      out_data <= prod_p0;
      out_id   <= gnt_idx;
    end
  end

endmodule

// File: doc/int_multiply_arbiter.md
# int_multiply_arbiter

Shares one signed integer multiplier (`int_multiply`) between `NUM_REQ` requesters using round-robin arbitration and valid/ready handshakes on every port. Each accepted operand pair yields one full-width signed product, tagged with the requester index, from a single registered output stage. The block sits between the per-lane operand producers of the matmul/LQER datapath and a shared result consumer. Its purpose is to save DSPs where lanes rarely multiply concurrently.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥1.
- `A_WIDTH`, default 8: signed width of operand a.
- `B_WIDTH`, default 8: signed width of operand b.
- `ID_WIDTH`, derived: `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`. Not user-overridable.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_a`  in  `[NUM_REQ][A_WIDTH]` signed  operand a, per requester.
- `req_b`  in  `[NUM_REQ][B_WIDTH]` signed  operand b, per requester.
- `req_valid`  in  `NUM_REQ`  operand pair valid, per requester.
- `req_ready`  out  `NUM_REQ`  pair accepted this cycle, per requester; at most one bit high.
- `out_data`  out  `A_WIDTH+B_WIDTH` signed  product.
- `out_id`  out  `ID_WIDTH`  index of the requester that produced `out_data`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- **Handshakes**
  - A transfer occurs when valid && ready on the same edge.
  - Requesters hold `req_valid`, `req_a` and `req_b` stable until their `req_ready` is high.
  - The output holds `out_data`, `out_id` and `out_valid` stable while `out_valid && !out_ready`.
- **Output register: two states.**
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
  - `can_accept = !out_valid || out_ready`.
- **Arbitration** (combinational)
  - `grant` is one-hot: the first requester with `req_valid` high, searching upward from `rr_ptr` with wrap-around.
  - `req_ready[i] = grant[i] && can_accept`.
  - `req_ready` must not depend combinationally on any `req_a` or `req_b` value.
- **Round-robin pointer**
  - On a requester transfer from index g: `rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1`.
  - Otherwise `rr_ptr` holds; there is no pointer update while stalled.
  - Fairness bound: a continuously valid requester is accepted within `NUM_REQ` consecutive requester transfers.
- **Accept**
  - Register `out_data <= a_g*b_g` (signed, full width, no rounding or saturation), `out_id <= g`, and `out_valid <= 1`.
- **Drain without accept**
  - If the output transfers and no requester transfers, `out_valid <= 0`.
  - `out_data` and `out_id` keep their last values.
- **Simultaneous drain and accept**
  - The register reloads with the new result and stays FULL, sustaining 1 result/cycle.
- **Reset**
  - `out_valid=0`, `out_data=0`, `out_id=0`, `rr_ptr=0` (requester 0 has first priority).
  - `req_ready` is all-zero during reset.
  - Reset mid-operation discards the held result. No partial state survives.
- **`NUM_REQ=1`**
  - `rr_ptr` is constant 0 and `out_id` is constant 0.

## Timing
- Latency: a requester transfer at edge N gives `out_valid=1` with its product visible after edge N (1 cycle).
- Throughput: 1 product/cycle while `out_ready` stays high.
- `req_ready` depends combinationally on `out_ready`.
  - Consumers must not make `out_ready` depend combinationally on `req_ready`.
- Critical path: the multiplier into the output register. There is no internal pipelining; widths ≤18×18 must fit one DSP stage.

## Structure
- Package `int_mul_arb_pkg`:
  - function `id_width(num_req)` used to derive `ID_WIDTH`;
  - enum `out_state_t {EMPTY, FULL}`.
- Sub-module: one `int_multiply` instance (`A_WIDTH`, `B_WIDTH`) fed by the operand mux selected by `grant`.
- Round-robin search is a local `always_comb` loop over `2*NUM_REQ` indices. There is no separate arbiter module.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `req_valid=1` → `req_ready=0000`, `out_valid=0`, `out_data=0`, `out_id=0`; first grant after release goes to requester 0.
- **Round-robin:** all 4 valid, `out_ready=1`, distinct operands → `out_id` sequence 0,1,2,3,0 on consecutive cycles; products match a signed reference model.
- **Signed extremes:** A=B=8.
  - a=-128, b=-128 → `out_data=16384` (0x4000).
  - a=-128, b=127 → -16256 (0xC080).
  - a=0, b=-1 → 0.
- **Backpressure:** `out_ready=0` for 5 cycles with requesters 1,2 valid.
  - One result is captured (id 1) and held unchanged.
  - `req_ready` stays 0 and `rr_ptr` stays unchanged.
  - On `out_ready=1`, id 2 is accepted in that same cycle.
- **Drain and fairness:** only requester 3 valid, then requester 0 joins while 3 stays valid.
  - Grants alternate 3,0,3,0.
  - When all valids drop, `out_valid` falls 1 cycle after the last output transfer.
- **Reset mid-operation:** FULL with `out_ready=0`, assert `rst` 1 cycle → `out_valid=0` next cycle and `rr_ptr` back to 0; the held result is never delivered.
